// File: rtl/cc_regbank_writer.sv
// Write side of the datapath register bank: decodes the C-bus destination from the MIR C field
// or the instruction rd field and commits C-bus data into 16 registers (r0 hardwired to zero).
module cc_regbank_writer #(
    parameter int DATAWIDTH_SCRATCHPAD_SELECTION = 5,
    parameter int DATAWIDTH_MIR_SELECTION        = 6,
    parameter int DATAWIDTH_BUS                  = 32,
    parameter int NUM_REGISTERS                  = 16
) (
    input  logic                                      CC_REGBANK_CLOCK_50,
    input  logic                                      CC_REGBANK_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data_InBus,
    input  logic                                      CC_REGBANK_Write_In,
    input  logic                                      CC_REGBANK_Select_In,
    input  logic [DATAWIDTH_MIR_SELECTION-1:0]        CC_REGBANK_MIRSelection_InBus,
    input  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] CC_REGBANK_ScratchpadSelection_InBus,
    input  logic                                      CC_REGBANK_ErrorClear_In,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data0_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data1_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data2_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data3_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data4_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data5_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data6_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data7_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data8_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data9_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data10_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data11_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data12_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data13_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data14_OutBus,
    output logic [DATAWIDTH_BUS-1:0]                  CC_REGBANK_data15_OutBus,
    output logic                                      CC_REGBANK_WriteAck_Out,
    output logic [NUM_REGISTERS-1:0]                  CC_REGBANK_Valid_OutBus,
    output logic                                      CC_REGBANK_Error_Out
);

    localparam int DEST_W = (DATAWIDTH_MIR_SELECTION > DATAWIDTH_SCRATCHPAD_SELECTION)
                          ? DATAWIDTH_MIR_SELECTION : DATAWIDTH_SCRATCHPAD_SELECTION;
    localparam int IDX_W  = $clog2(NUM_REGISTERS);
    localparam logic [DEST_W-1:0] NUM_REGS_D = DEST_W'(NUM_REGISTERS);

    logic [DATAWIDTH_BUS-1:0] regs_q [NUM_REGISTERS];
    logic [DATAWIDTH_BUS-1:0] regs_d [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] valid_q, valid_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;

    logic [DEST_W-1:0] dest;
    logic [IDX_W-1:0]  dest_idx;
    logic              in_range;
    logic              commit;
    logic              bad_write;

    always_comb begin
        dest      = CC_REGBANK_Select_In ? DEST_W'(CC_REGBANK_MIRSelection_InBus)
                                         : DEST_W'(CC_REGBANK_ScratchpadSelection_InBus);
        dest_idx  = dest[IDX_W-1:0];
        in_range  = (dest < NUM_REGS_D);
        commit    = CC_REGBANK_Write_In && in_range;
        bad_write = CC_REGBANK_Write_In && !in_range;
    end

    // r0 is never loaded, so it reads zero forever; a write to it is still acknowledged.
    always_comb begin
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            regs_d[i] = regs_q[i];
        end
        valid_d = valid_q;
        if (commit && (dest_idx != '0)) begin
            regs_d[dest_idx]  = CC_REGBANK_data_InBus;
            valid_d[dest_idx] = 1'b1;
        end
        ack_d = commit;
        // A new out-of-range write outranks a clear on the same edge.
        if (bad_write) begin
            err_d = 1'b1;
        end else if (CC_REGBANK_ErrorClear_In) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge CC_REGBANK_CLOCK_50 or negedge CC_REGBANK_RESET_InLow) begin
        if (!CC_REGBANK_RESET_InLow) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
            valid_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            valid_q <= valid_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign CC_REGBANK_data0_OutBus  = regs_q[0];
    assign CC_REGBANK_data1_OutBus  = regs_q[1];
    assign CC_REGBANK_data2_OutBus  = regs_q[2];
    assign CC_REGBANK_data3_OutBus  = regs_q[3];
    assign CC_REGBANK_data4_OutBus  = regs_q[4];
    assign CC_REGBANK_data5_OutBus  = regs_q[5];
    assign CC_REGBANK_data6_OutBus  = regs_q[6];
    assign CC_REGBANK_data7_OutBus  = regs_q[7];
    assign CC_REGBANK_data8_OutBus  = regs_q[8];
    assign CC_REGBANK_data9_OutBus  = regs_q[9];
    assign CC_REGBANK_data10_OutBus = regs_q[10];
    assign CC_REGBANK_data11_OutBus = regs_q[11];
    assign CC_REGBANK_data12_OutBus = regs_q[12];
    assign CC_REGBANK_data13_OutBus = regs_q[13];
    assign CC_REGBANK_data14_OutBus = regs_q[14];
    assign CC_REGBANK_data15_OutBus = regs_q[15];
    assign CC_REGBANK_WriteAck_Out  = ack_q;
    assign CC_REGBANK_Valid_OutBus  = valid_q;
    assign CC_REGBANK_Error_Out     = err_q;

endmodule

// File: tb/tb_cc_regbank_writer.sv
// Self-checking bench for cc_regbank_writer: directed vector table, hand-written reset/latency
// sequences, and randomized traffic against a simple array model of the register bank.
module tb_cc_regbank_writer;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        write;
    logic        sel;
    logic [5:0]  mir;
    logic [4:0]  sp;
    logic        clr;
    logic [31:0] dout [16];
    logic        ack;
    logic [15:0] valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_regs [16];
    logic [15:0] m_valid;
    logic        m_err;
    logic        m_ack;

    cc_regbank_writer dut (
        .CC_REGBANK_CLOCK_50                  (clk),
        .CC_REGBANK_RESET_InLow               (rst_n),
        .CC_REGBANK_data_InBus                (data_in),
        .CC_REGBANK_Write_In                  (write),
        .CC_REGBANK_Select_In                 (sel),
        .CC_REGBANK_MIRSelection_InBus        (mir),
        .CC_REGBANK_ScratchpadSelection_InBus (sp),
        .CC_REGBANK_ErrorClear_In             (clr),
        .CC_REGBANK_data0_OutBus              (dout[0]),
        .CC_REGBANK_data1_OutBus              (dout[1]),
        .CC_REGBANK_data2_OutBus              (dout[2]),
        .CC_REGBANK_data3_OutBus              (dout[3]),
        .CC_REGBANK_data4_OutBus              (dout[4]),
        .CC_REGBANK_data5_OutBus              (dout[5]),
        .CC_REGBANK_data6_OutBus              (dout[6]),
        .CC_REGBANK_data7_OutBus              (dout[7]),
        .CC_REGBANK_data8_OutBus              (dout[8]),
        .CC_REGBANK_data9_OutBus              (dout[9]),
        .CC_REGBANK_data10_OutBus             (dout[10]),
        .CC_REGBANK_data11_OutBus             (dout[11]),
        .CC_REGBANK_data12_OutBus             (dout[12]),
        .CC_REGBANK_data13_OutBus             (dout[13]),
        .CC_REGBANK_data14_OutBus             (dout[14]),
        .CC_REGBANK_data15_OutBus             (dout[15]),
        .CC_REGBANK_WriteAck_Out              (ack),
        .CC_REGBANK_Valid_OutBus              (valid),
        .CC_REGBANK_Error_Out                 (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [5:0]  mir;
        logic [4:0]  sp;
        logic [31:0] data;
        logic        wr;
        logic        clr;
        logic        exp_ack;
        logic        exp_err;
        logic [15:0] exp_valid;
        int          idx;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s data%0d", tag, i), dout[i], m_regs[i]);
        end
        chk({tag, " valid"}, {16'h0, valid}, {16'h0, m_valid});
        chk({tag, " err"}, {31'h0, err}, {31'h0, m_err});
        chk({tag, " ack"}, {31'h0, ack}, {31'h0, m_ack});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_valid = '0;
        m_err   = 1'b0;
        m_ack   = 1'b0;
    endtask

    // Apply one clock edge worth of the specification's rules to the model
    task automatic model_step();
        int d;
        d = sel ? int'(mir) : int'(sp);
        m_ack = 1'b0;
        if (write && d < 16) begin
            m_ack = 1'b1;
            if (d != 0) begin
                m_regs[d]  = data_in;
                m_valid[d] = 1'b1;
            end
        end
        if (write && d >= 16) m_err = 1'b1;
        else if (clr)         m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        write = 1'b0; sel = 1'b0; mir = '0; sp = '0; clr = 1'b0; data_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();
        #1;
        check_all("reset");

        // {sel, mir, sp, data, wr, clr, exp_ack, exp_err, exp_valid, idx, exp_val}
        vecs[0] = '{1'b1, 6'd5,  5'd0,  32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 6'd5,  5'd0,  32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 5,  32'hDEADBEEF};
        vecs[2] = '{1'b0, 6'd9,  5'd15, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8020, 15, 32'h12345678};
        vecs[3] = '{1'b0, 6'd9,  5'd15, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8020, 15, 32'h00000001};
        vecs[4] = '{1'b0, 6'd0,  5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h8020, 5,  32'hDEADBEEF};
        vecs[5] = '{1'b1, 6'd0,  5'd7,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8020, 0,  32'h0};
        vecs[6] = '{1'b1, 6'd40, 5'd3,  32'hAAAA5555, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8020, 5,  32'hDEADBEEF};
        vecs[7] = '{1'b0, 6'd2,  5'd20, 32'h55550000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8020, 2,  32'h0};
        vecs[8] = '{1'b0, 6'd0,  5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 16'h8020, 15, 32'h00000001};
        vecs[9] = '{1'b1, 6'd3,  5'd3,  32'h33333333, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8020, 3,  32'h0};

        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            sel = vecs[v].sel; mir = vecs[v].mir; sp = vecs[v].sp;
            data_in = vecs[v].data; write = vecs[v].wr; clr = vecs[v].clr;
            if (v == 0) chk("no bypass data5", dout[5], 32'h0);
            @(posedge clk);
            #1;
            $display("vec %0d: sel=%0d mir=%0d sp=%0d wr=%0d clr=%0d -> ack=%0d err=%0d valid=%h data%0d=%h",
                     v, sel, mir, sp, write, clr, ack, err, valid, vecs[v].idx, dout[vecs[v].idx]);
            chk($sformatf("vec%0d ack", v), {31'h0, ack}, {31'h0, vecs[v].exp_ack});
            chk($sformatf("vec%0d err", v), {31'h0, err}, {31'h0, vecs[v].exp_err});
            chk($sformatf("vec%0d valid", v), {16'h0, valid}, {16'h0, vecs[v].exp_valid});
            chk($sformatf("vec%0d data%0d", v, vecs[v].idx), dout[vecs[v].idx], vecs[v].exp_val);
            chk($sformatf("vec%0d data0", v), dout[0], 32'h0);
        end

        // Asynchronous reset arriving 2 ns after a committed write to r3
        do_reset();
        @(negedge clk);
        sel = 1'b1; mir = 6'd3; data_in = 32'hCAFEF00D; write = 1'b1;
        @(posedge clk);
        #1;
        chk("async pre data3", dout[3], 32'hCAFEF00D);
        #1;
        rst_n = 1'b0;
        #1;
        $display("async reset: data3=%h valid=%h err=%0d ack=%0d", dout[3], valid, err, ack);
        chk("async data3", dout[3], 32'h0);
        chk("async valid", {16'h0, valid}, 32'h0);
        chk("async err", {31'h0, err}, 32'h0);
        chk("async ack", {31'h0, ack}, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        #1;
        check_all("post-async");

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            sel     = 1'($urandom_range(0, 1));
            mir     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
            sp      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            data_in = $urandom;
            write   = ($urandom_range(0, 9) < 7);
            clr     = ($urandom_range(0, 4) == 0);
            #1;
            check_all("rnd-pre");
            @(posedge clk);
            model_step();
            #1;
            if (c % 40 == 0)
                $display("rnd %0d: sel=%0d mir=%0d sp=%0d wr=%0d clr=%0d ack=%0d err=%0d valid=%h",
                         c, sel, mir, sp, write, clr, ack, err, valid);
            check_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cc_regbank_writer.md
Name: cc_regbank_writer

Overview:
- Write-side counterpart of the datapath register read mux.
- Takes the C-bus result and decodes the destination from the MIR C field or the instruction scratchpad rd field.
- Writes that destination into a bank of 16 x DATAWIDTH_BUS registers.
- Drives all 16 register values as parallel outputs that feed the A/B read muxes. Also provides a write acknowledge, a written-valid mask and a sticky address-error flag.

Parameters:
DATAWIDTH_SCRATCHPAD_SELECTION, 5, width of instruction rd field destination select
DATAWIDTH_MIR_SELECTION, 6, width of MIR C field destination select
DATAWIDTH_BUS, 32, register and C-bus data width
NUM_REGISTERS, 16, number of implemented registers (fixed 16; selects >=16 are out of range)

Ports:
CC_REGBANK_CLOCK_50  input  1  system clock, rising edge active
CC_REGBANK_RESET_InLow  input  1  asynchronous, active-low reset
CC_REGBANK_data_InBus  input  DATAWIDTH_BUS  C-bus write data
CC_REGBANK_Write_In  input  1  write request, sampled at rising edge
CC_REGBANK_Select_In  input  1  0 = scratchpad select, 1 = MIR select
CC_REGBANK_MIRSelection_InBus  input  DATAWIDTH_MIR_SELECTION  MIR C-field destination
CC_REGBANK_ScratchpadSelection_InBus  input  DATAWIDTH_SCRATCHPAD_SELECTION  rd-field destination
CC_REGBANK_ErrorClear_In  input  1  clears sticky error flag
CC_REGBANK_data0_OutBus .. CC_REGBANK_data15_OutBus  output  DATAWIDTH_BUS each  register contents (16 ports)
CC_REGBANK_WriteAck_Out  output  1  one-cycle pulse, write committed
CC_REGBANK_Valid_OutBus  output  16  bit i = register i written since reset
CC_REGBANK_Error_Out  output  1  sticky: out-of-range write attempted

Behaviour:
- Reset: asynchronous, active-low; one clock; no other clock domains.
  - While reset is low, all registers, data0..15, WriteAck, Valid and Error are 0.
  - Reset asserted mid-write aborts the write; no partial state remains.
- Destination decode is combinational:
  - dest = MIRSelection when Select_In = 1.
  - dest = ScratchpadSelection, zero-extended, when Select_In = 0.
- Commit: on a rising edge with Write_In = 1 and dest in 1..15:
  - reg[dest] <= data_InBus.
  - Valid[dest] <= 1.
  - WriteAck = 1 for exactly the following cycle.
- Latency: new value appears on data<dest>_OutBus one cycle after the sampling edge. There is no read-during-write bypass; the old value is visible during the write cycle.
- dest = 0:
  - Register 0 is hardwired to zero; data0_OutBus is always 0 and Valid[0] stays 0.
  - The write is silently discarded. WriteAck still pulses, because the write is legal. Error is not set.
- dest >= 16 (MIR values 16..63, scratchpad 16..31):
  - No register changes and WriteAck stays 0.
  - Error <= 1 on that edge.
- Error is sticky until an edge with ErrorClear_In = 1 and no new out-of-range write. If a clear and a new out-of-range write occur on the same edge, the set wins and Error stays 1.
- Write_In = 0: the bank holds and WriteAck = 0, regardless of the select inputs.
- Back-to-back writes are accepted every cycle. WriteAck stays high on consecutive cycles, once per committed write.
- Every register output is a registered value; there is no combinational path from inputs to data outputs.

Test Plan:
- Reset low for 3 cycles, then release -> all data outs = 0, Valid = 16'h0000, Error = 0, WriteAck = 0.
- Select = 1, MIR = 6'd5, data = 32'hDEADBEEF, Write pulse -> data5_OutBus = DEADBEEF the next cycle; Valid = 16'h0020; WriteAck high 1 cycle.
- Select = 0, scratchpad = 5'd15, data = 32'h12345678, 2 consecutive writes (second data = 32'h0000_0001) -> data15 = 1 after the second edge; WriteAck high 2 cycles; other registers unchanged.
- Write to dest 0 with data = 32'hFFFFFFFF -> data0 stays 0; Valid[0] = 0; WriteAck pulses; Error = 0.
- MIR = 6'd40 write -> no register change, WriteAck = 0, Error = 1. Then ErrorClear together with an out-of-range write (scratchpad = 5'd20) -> Error remains 1. Then ErrorClear alone -> Error = 0.
- Write to reg 3 with reset asserted 2 ns after the edge -> data3 = 0 and Valid = 0 immediately, asynchronously; Error = 0.
